// File: rtl/bram_arbiter.sv
// Two-port arbiter in front of a single-port BRAM with 1-cycle read latency.
// Sticky priority with a burst limit under contention; read data returned per port.
module bram_arbiter #(
  parameter logic [15:0] P_OFFSET_MASK = 16'h00FF,
  parameter int unsigned P_MAX_BURST   = 4,
  parameter int unsigned P_PRIO        = 0
) (
  input  logic        I_CLK,
  input  logic        I_RESET,
  input  logic        I_REQ0,
  input  logic        I_REQ1,
  input  logic        I_WE0,
  input  logic        I_WE1,
  input  logic [15:0] I_ADDR0,
  input  logic [15:0] I_ADDR1,
  input  logic [7:0]  I_WDATA0,
  input  logic [7:0]  I_WDATA1,
  output logic        O_ACK0,
  output logic        O_ACK1,
  output logic        O_RVALID0,
  output logic        O_RVALID1,
  output logic [7:0]  O_RDATA0,
  output logic [7:0]  O_RDATA1,
  output logic        O_BRAM_EN,
  output logic        O_BRAM_WE,
  output logic [15:0] O_BRAM_ADDR,
  output logic [7:0]  O_BRAM_DIN,
  input  logic [7:0]  I_BRAM_DOUT
);

  localparam int unsigned CntW = $clog2(P_MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(P_MAX_BURST);
  localparam logic PrioBit = (P_PRIO != 0);

  logic            owner_q, owner_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      rd_pend_q, rd_pend_d;
  logic [7:0]      hold0_q, hold1_q;
  logic            grant;
  logic            win;

  always_comb begin
    grant   = 1'b0;
    win     = owner_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (!I_RESET) begin
      case ({I_REQ1, I_REQ0})
        2'b01: begin
          grant   = 1'b1;
          win     = 1'b0;
          owner_d = 1'b0;
          cnt_d   = '0;
        end
        2'b10: begin
          grant   = 1'b1;
          win     = 1'b1;
          owner_d = 1'b1;
          cnt_d   = '0;
        end
        2'b11: begin
          grant = 1'b1;
          if (cnt_q < MaxCnt) begin
            win   = owner_q;
            cnt_d = cnt_q + CntW'(1);
          end else begin
            // Owner exhausted its burst: hand over and count this grant as the first.
            win     = ~owner_q;
            owner_d = ~owner_q;
            cnt_d   = CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign O_ACK0      = grant & ~win;
  assign O_ACK1      = grant & win;
  assign O_BRAM_EN   = grant;
  assign O_BRAM_WE   = grant & (win ? I_WE1 : I_WE0);
  assign O_BRAM_ADDR = grant ? ((win ? I_ADDR1 : I_ADDR0) & P_OFFSET_MASK) : 16'h0000;
  assign O_BRAM_DIN  = grant ? (win ? I_WDATA1 : I_WDATA0) : 8'h00;

  assign rd_pend_d = {O_ACK1 & ~I_WE1, O_ACK0 & ~I_WE0};

  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      owner_q   <= PrioBit;
      cnt_q     <= '0;
      rd_pend_q <= 2'b00;
      hold0_q   <= 8'h00;
      hold1_q   <= 8'h00;
    end else begin
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      rd_pend_q <= rd_pend_d;
      if (rd_pend_q[0]) hold0_q <= I_BRAM_DOUT;
      if (rd_pend_q[1]) hold1_q <= I_BRAM_DOUT;
    end
  end

  assign O_RVALID0 = rd_pend_q[0] & ~I_RESET;
  assign O_RVALID1 = rd_pend_q[1] & ~I_RESET;
  assign O_RDATA0  = I_RESET ? 8'h00 : (rd_pend_q[0] ? I_BRAM_DOUT : hold0_q);
  assign O_RDATA1  = I_RESET ? 8'h00 : (rd_pend_q[1] ? I_BRAM_DOUT : hold1_q);

endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: directed scenarios then random traffic against a
// behavioural model of arbitration, memory contents and read return.
module tb_bram_arbiter;

  localparam int MX0 = 4;
  localparam int MX1 = 1;
  localparam logic [15:0] MASK = 16'h00FF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wd0, wd1;

  logic        ack0, ack1, rv0, rv1, en, we;
  logic [7:0]  rd0, rd1, bdin, bdout;
  logic [15:0] baddr;

  logic        ack0_b, ack1_b, rv0_b, rv1_b, en_b, we_b;
  logic [7:0]  rd0_b, rd1_b, bdin_b;
  logic [15:0] baddr_b;

  bram_arbiter #(.P_OFFSET_MASK(MASK), .P_MAX_BURST(MX0), .P_PRIO(0)) u_dut (
    .I_CLK(clk), .I_RESET(rst), .I_REQ0(req0), .I_REQ1(req1), .I_WE0(we0), .I_WE1(we1),
    .I_ADDR0(addr0), .I_ADDR1(addr1), .I_WDATA0(wd0), .I_WDATA1(wd1),
    .O_ACK0(ack0), .O_ACK1(ack1), .O_RVALID0(rv0), .O_RVALID1(rv1),
    .O_RDATA0(rd0), .O_RDATA1(rd1), .O_BRAM_EN(en), .O_BRAM_WE(we),
    .O_BRAM_ADDR(baddr), .O_BRAM_DIN(bdin), .I_BRAM_DOUT(bdout)
  );

  bram_arbiter #(.P_OFFSET_MASK(MASK), .P_MAX_BURST(MX1), .P_PRIO(0)) u_dut_b (
    .I_CLK(clk), .I_RESET(rst), .I_REQ0(req0), .I_REQ1(req1), .I_WE0(we0), .I_WE1(we1),
    .I_ADDR0(addr0), .I_ADDR1(addr1), .I_WDATA0(wd0), .I_WDATA1(wd1),
    .O_ACK0(ack0_b), .O_ACK1(ack1_b), .O_RVALID0(rv0_b), .O_RVALID1(rv1_b),
    .O_RDATA0(rd0_b), .O_RDATA1(rd1_b), .O_BRAM_EN(en_b), .O_BRAM_WE(we_b),
    .O_BRAM_ADDR(baddr_b), .O_BRAM_DIN(bdin_b), .I_BRAM_DOUT(8'h00)
  );

  // BRAM behind the main instance.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (en) begin
      if (we) mem[baddr[7:0]] <= bdin;
      else    bdout <= mem[baddr[7:0]];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: owner/run length per instance, expected memory, read return.
  int         owner [2];
  int         run   [2];
  int         g     [2];
  bit         pend  [2];
  logic [7:0] pdata [2];
  logic [7:0] hold  [2];
  logic [7:0] exp_mem [256];

  logic       s_ack0, s_ack1, s_ack1_b, s_rv0, s_rv1, s_we;
  logic [7:0] s_rd0, s_rd1;
  logic [15:0] s_addr;

  function automatic int limit(input int i);
    return (i == 0) ? MX0 : MX1;
  endfunction

  function automatic int winner(input int i);
    if (!req0 && !req1) return -1;
    if (req0 != req1) return req1 ? 1 : 0;
    return (run[i] < limit(i)) ? owner[i] : 1 - owner[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = 0;
      run[i]   = 0;
      pend[i]  = 1'b0;
      hold[i]  = 8'h00;
    end
  endtask

  // Inputs are applied just after a rising edge; outputs are checked on the falling edge.
  task automatic step();
    logic [7:0] a;
    @(negedge clk);
    for (int i = 0; i < 2; i++) g[i] = rst ? -1 : winner(i);
    s_ack0 = ack0; s_ack1 = ack1; s_ack1_b = ack1_b; s_rv0 = rv0; s_rv1 = rv1;
    s_rd0 = rd0; s_rd1 = rd1; s_addr = baddr; s_we = we;
    if (rst) begin
      chk("rst_ack0", {15'd0, ack0}, 16'd0);
      chk("rst_ack1", {15'd0, ack1}, 16'd0);
      chk("rst_rv0", {15'd0, rv0}, 16'd0);
      chk("rst_rv1", {15'd0, rv1}, 16'd0);
      chk("rst_en", {15'd0, en}, 16'd0);
      chk("rst_we", {15'd0, we}, 16'd0);
      chk("rst_rd0", {8'd0, rd0}, 16'd0);
      chk("rst_rd1", {8'd0, rd1}, 16'd0);
    end else begin
      chk("ack0", {15'd0, ack0}, {15'd0, g[0] == 0});
      chk("ack1", {15'd0, ack1}, {15'd0, g[0] == 1});
      chk("en", {15'd0, en}, {15'd0, g[0] != -1});
      chk("we", {15'd0, we}, {15'd0, (g[0] == 0) ? we0 : (g[0] == 1) ? we1 : 1'b0});
      chk("addr", baddr, (g[0] == 0) ? (addr0 & MASK) : (g[0] == 1) ? (addr1 & MASK) : 16'h0);
      chk("din", {8'd0, bdin}, {8'd0, (g[0] == 0) ? wd0 : (g[0] == 1) ? wd1 : 8'h00});
      chk("rv0", {15'd0, rv0}, {15'd0, pend[0]});
      chk("rv1", {15'd0, rv1}, {15'd0, pend[1]});
      chk("rd0", {8'd0, rd0}, {8'd0, pend[0] ? pdata[0] : hold[0]});
      chk("rd1", {8'd0, rd1}, {8'd0, pend[1] ? pdata[1] : hold[1]});
      chk("b_ack0", {15'd0, ack0_b}, {15'd0, g[1] == 0});
      chk("b_ack1", {15'd0, ack1_b}, {15'd0, g[1] == 1});
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (pend[n]) hold[n] = pdata[n];
        pend[n] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        if (g[i] >= 0) begin
          if (req0 && req1) begin
            if (g[i] == owner[i]) run[i]++;
            else begin owner[i] = g[i]; run[i] = 1; end
          end else begin
            owner[i] = g[i];
            run[i]   = 0;
          end
        end
      end
      if (g[0] >= 0) begin
        a = (g[0] == 0) ? addr0[7:0] & MASK[7:0] : addr1[7:0] & MASK[7:0];
        if ((g[0] == 0) ? we0 : we1) exp_mem[a] = (g[0] == 0) ? wd0 : wd1;
        else begin
          pend[g[0]]  = 1'b1;
          pdata[g[0]] = exp_mem[a];
        end
      end
    end
    #1;
  endtask

  initial begin
    model_reset();
    g[0] = -1; g[1] = -1;
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 16'h0001; addr1 = 16'h0002; wd0 = 8'hA1; wd1 = 8'hB2;
    @(posedge clk); #1;

    // Reset held with both requesting, then port 0 must win first.
    step(); step();
    rst = 1'b0;
    step();
    chk("t1_first_ack0", {15'd0, s_ack0}, 16'd1);

    // Fill memory through port 0 so every later read has a known value.
    req1 = 1'b0;
    for (int i = 0; i < 256; i++) begin
      addr0 = 16'(i) | 16'h5A00;
      wd0   = 8'($urandom);
      step();
    end

    // Write then read at an address whose upper byte is masked off.
    addr0 = 16'hC034; wd0 = 8'h12; we0 = 1'b1;
    step();
    chk("t2_addr", s_addr, 16'h0034);
    chk("t2_we", {15'd0, s_we}, 16'd1);
    chk("t2_ack", {15'd0, s_ack0}, 16'd1);
    we0 = 1'b0;
    step();
    req0 = 1'b0;
    step();
    chk("t2_rv0", {15'd0, s_rv0}, 16'd1);
    chk("t2_rd0", {8'd0, s_rd0}, 16'h0012);

    // Contention: burst of 4 (main) versus strict alternation (second instance).
    req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wd0 = 8'h10;
    step();
    req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0011; wd1 = 8'h11;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t3_burst", {15'd0, s_ack1}, 16'((k / 4) % 2));
      chk("t4_alt", {15'd0, s_ack1_b}, 16'(k % 2));
    end
    req0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_alone", {15'd0, s_ack1_b}, 16'd1);
    end

    // Port 1 read followed by port 0 write.
    we1 = 1'b0; addr1 = 16'hFF55;
    step();
    req1 = 1'b0; req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0077; wd0 = 8'h77;
    step();
    chk("t5_rv1", {15'd0, s_rv1}, 16'd1);
    chk("t5_rd1", {8'd0, s_rd1}, {8'd0, exp_mem[8'h55]});
    chk("t5_rv0", {15'd0, s_rv0}, 16'd0);
    req0 = 1'b0;
    step(); step();
    chk("t5_hold", {8'd0, s_rd1}, {8'd0, exp_mem[8'h55]});
    chk("t5_rv1_off", {15'd0, s_rv1}, 16'd0);

    // Read granted, then reset the next cycle: the return is dropped.
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0077;
    step();
    rst = 1'b1; req0 = 1'b0;
    step();
    chk("t6_rv0_a", {15'd0, s_rv0}, 16'd0);
    rst = 1'b0;
    step();
    chk("t6_rv0_b", {15'd0, s_rv0}, 16'd0);
    chk("t6_rd0", {8'd0, s_rd0}, 16'd0);

    // Random traffic; fields change only once the current request is accepted.
    for (int c = 0; c < 600; c++) begin
      if (!req0 || g[0] == 0) begin
        req0 = ($urandom_range(0, 3) != 0); we0 = 1'($urandom);
        addr0 = 16'($urandom); wd0 = 8'($urandom);
      end
      if (!req1 || g[0] == 1) begin
        req1 = ($urandom_range(0, 3) != 0); we1 = 1'($urandom);
        addr1 = 16'($urandom); wd1 = 8'($urandom);
      end
      rst = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
